// File: rtl/connect4_win_checker_if.sv
// Handshake and result bundle between the board controller and the Connect4 win checker.
// The controller drives the scan request and board; the checker returns scan status and the result.
interface connect4_win_checker_if #(
  parameter int ROWS = 6,
  parameter int COLS = 7
);
  logic                     start;
  logic                     new_game;
  logic [2*ROWS*COLS-1:0]   board;
  logic                     busy;
  logic                     done;
  logic                     winner_valid;
  logic                     winner_color;
  logic                     draw;
  logic [2:0]               win_row;
  logic [2:0]               win_col;
  logic [1:0]               win_dir;

  modport master (
    output start, new_game, board,
    input  busy, done, winner_valid, winner_color, draw, win_row, win_col, win_dir
  );

  modport slave (
    input  start, new_game, board,
    output busy, done, winner_valid, winner_color, draw, win_row, win_col, win_dir
  );
endinterface

// File: rtl/connect4_win_checker.sv
// Sequential Connect4 line scanner: snapshots the board, tests one (anchor, direction) pair per
// cycle in ascending order, and reports the first winning line or a draw.
module connect4_win_checker #(
  parameter int ROWS    = 6,
  parameter int COLS    = 7,
  parameter int WIN_LEN = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  connect4_win_checker_if.slave  bus
);
  localparam int BW = 2 * ROWS * COLS;
  localparam int IW = $clog2(BW);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t          state, state_next;
  logic [BW-1:0]   snap;
  logic [2:0]      scan_row, scan_col;
  logic [1:0]      scan_dir;
  logic            load, advance, hit, top_full, last_step;
  logic [1:0]      anchor_cell, top_cell;
  int              r, c, dr, dc;

  logic            busy_q, done_q, winner_valid_q, winner_color_q, draw_q;
  logic [2:0]      win_row_q, win_col_q;
  logic [1:0]      win_dir_q;

  function automatic logic [1:0] cell_at(input logic [BW-1:0] b, input int row, input int col);
    logic [IW-1:0] base;
    base = IW'(2 * (row * COLS + col));
    return b[base +: 2];
  endfunction

  // Evaluate the current step: anchor must be a player piece and every further cell in range and equal.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    anchor_cell = cell_at(snap, int'(scan_row), int'(scan_col));
    hit         = (anchor_cell == 2'b01) || (anchor_cell == 2'b10);
    r           = 0;
    c           = 0;
    case (scan_dir)
      2'd0:    begin dr = 0; dc = 1;  end
      2'd1:    begin dr = 1; dc = 0;  end
      2'd2:    begin dr = 1; dc = 1;  end
      default: begin dr = 1; dc = -1; end
    endcase
    for (int i = 1; i < WIN_LEN; i++) begin
      r = int'(scan_row) + dr * i;
      c = int'(scan_col) + dc * i;
      if (r < 0 || r >= ROWS || c < 0 || c >= COLS) hit = 1'b0;
      else if (cell_at(snap, r, c) != anchor_cell)   hit = 1'b0;
    end
  end

  always_comb begin
    top_full = 1'b1;
    top_cell = 2'b00;
    for (int col = 0; col < COLS; col++) begin
      top_cell = cell_at(snap, ROWS - 1, col);
      if (top_cell == 2'b00 || top_cell == 2'b11) top_full = 1'b0;
    end
  end

  assign last_step = (scan_row == 3'(ROWS - 1)) && (scan_col == 3'(COLS - 1)) && (scan_dir == 2'd3);

  // new_game overrides everything, including a start or hit in the same cycle.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    advance    = 1'b0;
    if (bus.new_game) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: if (bus.start && !winner_valid_q && !draw_q) begin
          state_next = SCAN;
          load       = 1'b1;
        end
        SCAN: if (hit || last_step) state_next = DONE;
              else                  advance    = 1'b1;
        DONE: state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      // NOTE: the snapshot is ordinary flops rather than a RAM, so it is cleared with everything else.
      snap           <= '0;
      scan_row       <= '0;
      scan_col       <= '0;
      scan_dir       <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      winner_valid_q <= 1'b0;
      winner_color_q <= 1'b0;
      draw_q         <= 1'b0;
      win_row_q      <= '0;
      win_col_q      <= '0;
      win_dir_q      <= '0;
    end else begin
      busy_q <= (state_next != IDLE);
      done_q <= (state == SCAN) && (state_next == DONE);
      if (bus.new_game) begin
        winner_valid_q <= 1'b0;
        winner_color_q <= 1'b0;
        draw_q         <= 1'b0;
        win_row_q      <= '0;
        win_col_q      <= '0;
        win_dir_q      <= '0;
      end else if (state == SCAN && hit) begin
        winner_valid_q <= 1'b1;
        winner_color_q <= (anchor_cell == 2'b01);
        win_row_q      <= scan_row;
        win_col_q      <= scan_col;
        win_dir_q      <= scan_dir;
      end else if (state == SCAN && last_step) begin
        draw_q <= top_full;
      end
      if (load) begin
        snap     <= bus.board;
        scan_row <= '0;
        scan_col <= '0;
        scan_dir <= '0;
      end else if (advance) begin
        scan_dir <= scan_dir + 2'd1;
        if (scan_dir == 2'd3) begin
          if (scan_col == 3'(COLS - 1)) begin
            scan_col <= '0;
            scan_row <= scan_row + 3'd1;
          end else begin
            scan_col <= scan_col + 3'd1;
          end
        end
      end
    end
  end

  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.winner_valid = winner_valid_q;
  assign bus.winner_color = winner_color_q;
  assign bus.draw         = draw_q;
  assign bus.win_row      = win_row_q;
  assign bus.win_col      = win_col_q;
  assign bus.win_dir      = win_dir_q;
endmodule

// File: tb/tb_connect4_win_checker.sv
// Scoreboard bench for connect4_win_checker: directed boards from the test plan plus random boards,
// each checked against a plain array-based line search done by the bench.
module tb_connect4_win_checker;
  localparam int ROWS    = 6;
  localparam int COLS    = 7;
  localparam int WIN_LEN = 4;
  localparam int BW      = 2 * ROWS * COLS;
  localparam int STEPS   = ROWS * COLS * 4;

  typedef logic [BW-1:0] board_t;
  typedef struct {
    int cycle;
    bit win;
    bit color;
    bit draw;
    int row;
    int col;
    int dir;
  } exp_t;

  logic   clk = 1'b0;
  logic   rst;
  int     cyc = 0;
  int     vectors = 0;
  int     miscompares = 0;
  exp_t   q[$];
  bit     over = 1'b0;

  connect4_win_checker_if #(.ROWS(ROWS), .COLS(COLS)) bus ();

  connect4_win_checker #(.ROWS(ROWS), .COLS(COLS), .WIN_LEN(WIN_LEN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish (time %0t)", $time);
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic board_t put(input board_t b, input int row, input int col, input logic [1:0] v);
    int sh;
    sh = 2 * (row * COLS + col);
    b = (b & ~(board_t'(3) << sh)) | (board_t'(v) << sh);
    return b;
  endfunction

  // Reference: plain grid search over anchors then directions; first line found wins.
  function automatic exp_t ref_model(input board_t b, input int t);
    int   g[ROWS][COLS];
    int   dr[4] = '{0, 1, 1, 1};
    int   dc[4] = '{1, 0, 1, -1};
    exp_t e;
    logic [1:0] v;
    bit   ok;
    int   rr, cc;
    e.win = 0; e.color = 0; e.draw = 0; e.row = 0; e.col = 0; e.dir = 0;
    for (int row = 0; row < ROWS; row++)
      for (int col = 0; col < COLS; col++) begin
        v = 2'(b >> (2 * (row * COLS + col)));
        g[row][col] = (v == 2'b01 || v == 2'b10) ? int'(v) : 0;
      end
    for (int a = 0; a < ROWS * COLS; a++)
      for (int d = 0; d < 4; d++) begin
        ok = (g[a / COLS][a % COLS] != 0);
        for (int i = 1; i < WIN_LEN; i++) begin
          rr = a / COLS + dr[d] * i;
          cc = a % COLS + dc[d] * i;
          if (rr < 0 || rr >= ROWS || cc < 0 || cc >= COLS) ok = 0;
          else if (g[rr][cc] != g[a / COLS][a % COLS])     ok = 0;
        end
        if (ok) begin
          e.win   = 1;
          e.color = (g[a / COLS][a % COLS] == 1);
          e.row   = a / COLS;
          e.col   = a % COLS;
          e.dir   = d;
          e.cycle = t + 1 + a * 4 + d;
          return e;
        end
      end
    e.draw = 1;
    for (int col = 0; col < COLS; col++)
      if (g[ROWS - 1][col] == 0) e.draw = 0;
    e.cycle = t + STEPS;
    return e;
  endfunction

  function automatic board_t random_board(input int density);
    board_t b = '0;
    int     x;
    for (int row = 0; row < ROWS; row++)
      for (int col = 0; col < COLS; col++) begin
        x = $urandom_range(0, 99);
        if (x < density)          b = put(b, row, col, 2'($urandom_range(1, 2)));
        else if (x < density + 5) b = put(b, row, col, 2'b11);
      end
    return b;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst === 1'b1 && bus.done === 1'b1) begin
      if (q.size() == 0) begin
        check("done_unexpected", bus.done, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("done_cycle", cyc, e.cycle);
        check("winner_valid", bus.winner_valid, e.win);
        if (e.win) check("winner_color", bus.winner_color, e.color);
        check("draw", bus.draw, e.draw);
        check("win_row", bus.win_row, e.row);
        check("win_col", bus.win_col, e.col);
        check("win_dir", bus.win_dir, e.dir);
      end
    end
  end

  task automatic play(input board_t b, input string tag);
    exp_t e;
    int   t;
    bit   locked;
    locked = over;
    @(negedge clk);
    bus.board = b;
    bus.start = 1'b1;
    @(posedge clk);
    #1 t = cyc;
    if (!locked) begin
      e = ref_model(b, t);
      q.push_back(e);
      over = e.win || e.draw;
    end
    @(negedge clk);
    bus.start = 1'b0;
    bus.board = random_board(60);
    check({tag, "_busy"}, bus.busy, !locked);
    for (int i = 0; i < STEPS + 20 && q.size() != 0; i++) @(negedge clk);
    check({tag, "_drained"}, q.size(), 0);
    q.delete();
    repeat (3) @(negedge clk);
    check({tag, "_idle"}, bus.busy, 0);
  endtask

  task automatic new_game_pulse(input string tag);
    @(negedge clk);
    bus.new_game = 1'b1;
    @(negedge clk);
    bus.new_game = 1'b0;
    over = 1'b0;
    check({tag, "_ng_busy"}, bus.busy, 0);
    check({tag, "_ng_valid"}, bus.winner_valid, 0);
    check({tag, "_ng_draw"}, bus.draw, 0);
    check({tag, "_ng_loc"}, {bus.win_row, bus.win_col, bus.win_dir}, 0);
  endtask

  initial begin
    board_t b;
    rst          = 1'b0;
    bus.start    = 1'b0;
    bus.new_game = 1'b0;
    bus.board    = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_valid", bus.winner_valid, 0);
    check("rst_color", bus.winner_color, 0);
    check("rst_draw", bus.draw, 0);
    check("rst_loc", {bus.win_row, bus.win_col, bus.win_dir}, 0);
    rst = 1'b1;

    play('0, "empty");

    b = '0;
    for (int col = 4; col < COLS; col++) b = put(b, 0, col, 2'b01);
    b = put(b, 1, 0, 2'b01);
    play(b, "nowrap");

    b = '0;
    for (int col = 0; col < 4; col++) b = put(b, 0, col, 2'b01);
    play(b, "horiz");
    play(b, "locked_win");
    new_game_pulse("horiz");

    b = '0;
    for (int i = 0; i < 4; i++) b = put(b, i, 6 - i, 2'b10);
    play(b, "antidiag");
    new_game_pulse("antidiag");

    b = '0;
    for (int row = 0; row < ROWS; row++)
      for (int col = 0; col < COLS; col++)
        b = put(b, row, col, ((((col >> 1) + row) & 1) != 0) ? 2'b10 : 2'b01);
    play(b, "draw");
    check("draw_sticky", bus.draw, 1);
    play(b, "locked_draw");
    new_game_pulse("draw");

    // Abort: new_game mid-scan must end the scan without a done pulse.
    @(negedge clk);
    bus.board = '0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (8) @(negedge clk);
    bus.new_game = 1'b1;
    @(negedge clk);
    bus.new_game = 1'b0;
    check("abort_busy", bus.busy, 0);
    check("abort_done", bus.done, 0);
    repeat (STEPS + 5) @(negedge clk);
    check("abort_idle", bus.busy, 0);

    // Simultaneous new_game and start: no scan begins.
    @(negedge clk);
    bus.start    = 1'b1;
    bus.new_game = 1'b1;
    @(negedge clk);
    bus.start    = 1'b0;
    bus.new_game = 1'b0;
    check("ng_start_busy", bus.busy, 0);
    repeat (3) @(negedge clk);
    check("ng_start_idle", bus.busy, 0);

    for (int n = 0; n < 24; n++) begin
      play(random_board((n % 3 == 0) ? 20 : 45), "rand");
      if (over) new_game_pulse("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/connect4_win_checker.md
Name: connect4_win_checker

Overview:
Upstream stage of the Connect4 winner overlay. After each piece is dropped, the block takes a snapshot of the board and scans it for WIN_LEN-in-a-row. It then drives the winner flag and colour that gate and colour the on-screen winner text. It also reports a draw and the location of the winning line, which the board renderer uses for highlighting.

Parameters:
ROWS, 6, board rows; row 0 is the bottom.
COLS, 7, board columns; col 0 is the left edge.
WIN_LEN, 4, pieces in a line required to win.

Ports:
clk  in  1  system clock; all logic on the rising edge.
rst  in  1  synchronous, active-low reset.
start  in  1  one-cycle pulse: a piece has been placed and the board is stable.
new_game  in  1  one-cycle pulse: clear all result state.
board  in  2*ROWS*COLS  cell i = row*COLS+col at bits [2i+1:2i]; 00 empty, 01 player1, 10 player2, 11 treated as empty.
busy  out  1  high while a scan is in progress (SCAN or DONE state).
done  out  1  one-cycle pulse when a scan finishes.
winner_valid  out  1  sticky; a win has been found.
winner_color  out  1  1 = player1 (red), 0 = player2 (cyan); meaningful only when winner_valid=1.
draw  out  1  sticky; no win and top row is full.
win_row  out  3  anchor row of the winning line.
win_col  out  3  anchor column of the winning line.
win_dir  out  2  0 horizontal (+col), 1 vertical (+row), 2 diagonal (+row,+col), 3 anti-diagonal (+row,−col).

Behaviour:
- Reset (rst=0 at a clock edge):
  - state=IDLE.
  - busy, done, winner_valid, winner_color, draw, win_row, win_col, win_dir all 0.
  - Internal board snapshot and step counter are cleared.
- FSM states: IDLE, SCAN, DONE.
- IDLE:
  - start=1 with winner_valid=0, draw=0 and new_game=0 → latch board into the snapshot, zero the step counter, go to SCAN.
  - start is ignored while winner_valid=1 or draw=1 (game over).
- SCAN evaluates one step per cycle, k = 0..ROWS*COLS*4−1:
  - anchor index = k>>2, direction = k[1:0]; anchor cell index ascending, direction ascending within each cell.
  - A step hits when all WIN_LEN cells along the direction are in bounds, equal, and non-empty (01 or 10).
  - Out-of-bounds cells make the step a miss; no wrap-around between rows or columns.
  - On a hit: register winner_valid=1, winner_color=(cell==01), and win_row/win_col/win_dir = the anchor and direction; go to DONE.
  - The first hit in scan order is authoritative; later lines are not examined.
  - Last step with no hit: if no top-row cell of the snapshot is empty, set draw=1; go to DONE.
- DONE: done=1 for exactly one cycle, then go to IDLE.
- busy=1 in SCAN and DONE, 0 in IDLE.
- Latency: start accepted at edge t → step k is evaluated in cycle t+1+k.
  - Hit at step k → done=1 and results visible in cycle t+2+k.
  - No hit → done=1 in cycle t+1+ROWS*COLS*4 (t+169 with default parameters).
- board changes during a scan have no effect; only the snapshot is used.
- start during SCAN or DONE is ignored; it is not queued.
- new_game in any state → next cycle: IDLE, winner_valid, draw, win_* and done all 0.
  - An in-flight scan is aborted with no done pulse.
  - new_game takes priority over a simultaneous start or hit.
- Outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- Reset: hold rst=0 for 2 cycles → all outputs 0, busy=0. Pulse start with an empty board → done at t+169, winner_valid=0, draw=0.
- Horizontal win: player1 in row0 cols0–3, start at t → done at t+2, winner_valid=1, winner_color=1, win_row=0, win_col=0, win_dir=0.
- Anti-diagonal win: player2 at (0,6),(1,5),(2,4),(3,3), start → step k=6*4+3=27, done at t+29, winner_color=0, win_row=0, win_col=6, win_dir=3.
- No wrap-around: player1 at row0 cols4–6 plus row1 col0 → no hit, done at t+169, winner_valid=0.
- Draw: full board alternating so that no line of 4 exists → done at t+169, draw=1. A subsequent start produces no busy and no done.
- Abort and lockout:
  - new_game at t+10 during a scan → busy=0 at t+11, no done pulse, outputs 0.
  - After a win, a start pulse is ignored until new_game.
  - new_game and start in the same cycle → IDLE, no scan.
